// File: rtl/jacobi_pivot_search_pkg.sv
// Shared types for the Jacobi eigen-solver pipeline: pivot search, rotation and
// convergence stages all import this package.
package jacobi_pivot_search_pkg;

    localparam int ELEM_WIDTH   = 16;
    localparam int ELEM_FRACT   = 8;
    localparam int N_STOCKS_DEF = 4;

    typedef logic signed [ELEM_WIDTH-1:0]     elem_t;
    typedef logic [$clog2(N_STOCKS_DEF)-1:0]  idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

endpackage

// File: rtl/jacobi_pivot_search_abs_sat.sv
// Saturating magnitude of a signed fixed-point element; the most negative code
// maps to the largest positive code so the result always fits in WIDTH bits.
module abs_sat #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] value_in,
    output logic [WIDTH-1:0]        mag_out
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};

    logic [WIDTH-1:0] raw;

    assign raw = value_in;

    always_comb begin
        if (raw == MOST_NEG) begin
            mag_out = MAX_POS;
        end else if (raw[WIDTH-1]) begin
            mag_out = -raw;
        end else begin
            mag_out = raw;
        end
    end

endmodule

// File: rtl/jacobi_pivot_search.sv
// Sequential pivot finder: scans the strict upper triangle of a latched matrix one
// element per cycle and reports the largest-magnitude off-diagonal entry (p,q).
module jacobi_pivot_search
    import jacobi_pivot_search_pkg::*;
#(
    parameter int WIDTH    = ELEM_WIDTH,
    parameter int FRACT    = ELEM_FRACT,
    parameter int N_STOCKS = N_STOCKS_DEF
) (
    input  logic                                             clk_in,
    input  logic                                             rst_in,
    input  logic                                             start_in,
    input  logic                                             conv_in,
    input  logic signed [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] matrix_in,
    output logic                                             busy_out,
    output logic                                             valid_out,
    output logic                                             converged_out,
    output logic                                             zero_pivot_out,
    output logic [$clog2(N_STOCKS)-1:0]                      p_out,
    output logic [$clog2(N_STOCKS)-1:0]                      q_out,
    output logic signed [WIDTH-1:0]                          a_pp_out,
    output logic signed [WIDTH-1:0]                          a_qq_out,
    output logic signed [WIDTH-1:0]                          a_pq_out
);

    localparam int IDX_W = $clog2(N_STOCKS);

    typedef logic [IDX_W-1:0] index_t;
    typedef logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] matrix_t;

    localparam index_t LAST_I = index_t'(N_STOCKS - 2);
    localparam index_t LAST_J = index_t'(N_STOCKS - 1);

    if (N_STOCKS < 2 || FRACT < 0 || FRACT >= WIDTH) begin : g_bad_params
        $error("jacobi_pivot_search: need N_STOCKS >= 2 and 0 <= FRACT < WIDTH");
    end

    state_t           state_q, state_d;
    matrix_t          matrix_q, matrix_d;
    index_t           i_q, i_d, j_q, j_d;
    index_t           best_p_q, best_p_d, best_q_q, best_q_d;
    logic [WIDTH-1:0] best_mag_q, best_mag_d;
    logic [WIDTH-1:0] cand_mag;
    logic             conv_q, conv_d, zero_q, zero_d;
    index_t           p_q, p_d, q_q, q_d;
    logic [WIDTH-1:0] a_pp_q, a_pp_d, a_qq_q, a_qq_d, a_pq_q, a_pq_d;

    abs_sat #(.WIDTH(WIDTH)) u_abs_sat (
        .value_in (matrix_q[i_q][j_q]),
        .mag_out  (cand_mag)
    );

    always_comb begin
        state_d    = state_q;
        matrix_d   = matrix_q;
        i_d        = i_q;
        j_d        = j_q;
        best_p_d   = best_p_q;
        best_q_d   = best_q_q;
        best_mag_d = best_mag_q;
        conv_d     = conv_q;
        zero_d     = zero_q;
        p_d        = p_q;
        q_d        = q_q;
        a_pp_d     = a_pp_q;
        a_qq_d     = a_qq_q;
        a_pq_d     = a_pq_q;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    matrix_d   = matrix_in;
                    i_d        = '0;
                    j_d        = index_t'(1);
                    best_p_d   = '0;
                    best_q_d   = index_t'(1);
                    best_mag_d = '0;
                    if (conv_in) begin
                        // Already converged: publish the (0,1) entry without scanning.
                        state_d = DONE;
                        conv_d  = 1'b1;
                        zero_d  = 1'b0;
                        p_d     = '0;
                        q_d     = index_t'(1);
                        a_pp_d  = matrix_in[0][0];
                        a_qq_d  = matrix_in[1][1];
                        a_pq_d  = matrix_in[0][1];
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (cand_mag > best_mag_q) begin
                    best_mag_d = cand_mag;
                    best_p_d   = i_q;
                    best_q_d   = j_q;
                end
                // Results load on the last element so they are visible during DONE.
                if (i_q == LAST_I && j_q == LAST_J) begin
                    state_d = DONE;
                    conv_d  = 1'b0;
                    zero_d  = (best_mag_d == '0);
                    p_d     = best_p_d;
                    q_d     = best_q_d;
                    a_pp_d  = matrix_q[best_p_d][best_p_d];
                    a_qq_d  = matrix_q[best_q_d][best_q_d];
                    a_pq_d  = matrix_q[best_p_d][best_q_d];
                end else if (j_q == LAST_J) begin
                    i_d = i_q + index_t'(1);
                    j_d = i_q + index_t'(2);
                end else begin
                    j_d = j_q + index_t'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            matrix_q   <= '0;
            i_q        <= '0;
            j_q        <= '0;
            best_p_q   <= '0;
            best_q_q   <= '0;
            best_mag_q <= '0;
            conv_q     <= 1'b0;
            zero_q     <= 1'b0;
            p_q        <= '0;
            q_q        <= '0;
            a_pp_q     <= '0;
            a_qq_q     <= '0;
            a_pq_q     <= '0;
        end else begin
            state_q    <= state_d;
            matrix_q   <= matrix_d;
            i_q        <= i_d;
            j_q        <= j_d;
            best_p_q   <= best_p_d;
            best_q_q   <= best_q_d;
            best_mag_q <= best_mag_d;
            conv_q     <= conv_d;
            zero_q     <= zero_d;
            p_q        <= p_d;
            q_q        <= q_d;
            a_pp_q     <= a_pp_d;
            a_qq_q     <= a_qq_d;
            a_pq_q     <= a_pq_d;
        end
    end

    assign busy_out       = (state_q == SCAN);
    assign valid_out      = (state_q == DONE);
    assign converged_out  = conv_q;
    assign zero_pivot_out = zero_q;
    assign p_out          = p_q;
    assign q_out          = q_q;
    assign a_pp_out       = a_pp_q;
    assign a_qq_out       = a_qq_q;
    assign a_pq_out       = a_pq_q;

endmodule
